// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - segment/anode code constants and FSM state encoding for the scan decoder
package sevseg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [3:0] AN_THOUS = 4'b0111;
  localparam logic [3:0] AN_HUND  = 4'b1011;
  localparam logic [3:0] AN_TENS  = 4'b1101;
  localparam logic [3:0] AN_ONES  = 4'b1110;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_CONVERT = 2'd2;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low segment code to BCD digit decoder
module seg7_to_bcd
  import sevseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] bcd
);

  always_comb begin
    valid = 1'b1;
    bcd   = 4'd0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - snoops a 4-digit seven-segment scan bus and rebuilds the binary value
// Optional: SEVSEG_CHANGE_ONLY_EN suppresses num_valid when a completed frame repeats the current value.
module seven_seg_scan_decoder
  import sevseg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  seg_in,
  output logic [13:0] num_out,
  output logic [15:0] digits_out,
  output logic        num_valid,
  output logic        frame_err
);

  localparam int CW = $clog2(SETTLE_CYCLES);

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt;
  logic          evt;
  logic          in_chg;

  assign in_chg = ({anode_in, seg_in} != {an_q, seg_q});

  // evt rises on the one cycle the counter first holds SETTLE_CYCLES-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q  <= '0;
      seg_q <= '0;
      cnt   <= '0;
      evt   <= 1'b0;
    end else begin
      an_q  <= anode_in;
      seg_q <= seg_in;
      if (in_chg) begin
        cnt <= '0;
        evt <= 1'b0;
      end else begin
        evt <= (cnt == CW'(SETTLE_CYCLES - 2));
        if (cnt != CW'(SETTLE_CYCLES - 1))
          cnt <= cnt + CW'(1);
      end
    end
  end

  logic       dig_ok;
  logic [3:0] dig_val;

  seg7_to_bcd u_dec (
    .seg   (seg_q),
    .valid (dig_ok),
    .bcd   (dig_val)
  );

  logic [1:0] slot;
  logic       slot_ok;
  logic       sample;

  always_comb begin
    slot    = 2'd0;
    slot_ok = 1'b1;
    case (an_q)
      AN_THOUS: slot = 2'd3;
      AN_HUND:  slot = 2'd2;
      AN_TENS:  slot = 2'd1;
      AN_ONES:  slot = 2'd0;
      default:  slot_ok = 1'b0;
    endcase
  end

  assign sample = evt && slot_ok;

  state_t      state;
  logic [1:0]  exp_slot;
  logic [15:0] dig_q;
  logic [1:0]  step;
  logic [13:0] acc;
  logic [13:0] acc_next;
  logic [3:0]  cur_digit;

  assign cur_digit = dig_q[{step, 2'b00} +: 4];
  assign acc_next  = (acc << 3) + (acc << 1) + {10'd0, cur_digit};

`ifdef SEVSEG_CHANGE_ONLY_EN
  logic seen_frame;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      exp_slot   <= 2'd0;
      dig_q      <= '0;
      step       <= 2'd0;
      acc        <= '0;
      num_out    <= '0;
      digits_out <= '0;
      num_valid  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SEVSEG_CHANGE_ONLY_EN
      seen_frame <= 1'b0;
`endif
    end else begin
      num_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample && slot == 2'd3 && dig_ok) begin
            dig_q[15:12] <= dig_val;
            exp_slot     <= 2'd2;
            state        <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (sample) begin
            if (slot == 2'd3 && dig_ok) begin
              dig_q[15:12] <= dig_val;
              exp_slot     <= 2'd2;
            end else if (!dig_ok || slot != exp_slot) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              dig_q[{slot, 2'b00} +: 4] <= dig_val;
              if (slot == 2'd0) begin
                state <= ST_CONVERT;
                step  <= 2'd3;
                acc   <= '0;
              end else begin
                exp_slot <= exp_slot - 2'd1;
              end
            end
          end
        end
        ST_CONVERT: begin
          acc  <= acc_next;
          step <= step - 2'd1;
          if (step == 2'd0) begin
            num_out    <= acc_next;
            digits_out <= dig_q;
            state      <= ST_IDLE;
`ifdef SEVSEG_CHANGE_ONLY_EN
            num_valid  <= !seen_frame || (acc_next != num_out);
            seen_frame <= 1'b1;
`else
            num_valid  <= 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb/tb_seven_seg_scan_decoder.sv - table-driven plus directed-sequence bench for the scan decoder
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  anode_in = 4'b1111;
  logic [6:0]  seg_in = 7'b1111111;
  logic [13:0] num_out;
  logic [15:0] digits_out;
  logic        num_valid;
  logic        frame_err;

  seven_seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .anode_in   (anode_in),
    .seg_in     (seg_in),
    .num_out    (num_out),
    .digits_out (digits_out),
    .num_valid  (num_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nv_cnt = 0;
  int fe_cnt = 0;
  int last_nv_cyc = -1;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (num_valid) begin
      nv_cnt++;
      last_nv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
  end

  localparam logic [3:0] A_TH = 4'b0111;
  localparam logic [3:0] A_HU = 4'b1011;
  localparam logic [3:0] A_TE = 4'b1101;
  localparam logic [3:0] A_ON = 4'b1110;
  localparam logic [3:0] A_BL = 4'b1111;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
    anode_in = an;
    seg_in   = sg;
    wait_cyc(n);
  endtask

  task automatic send_frame(input int d3, input int d2, input int d1, input int d0,
                            output int ones_cyc);
    hold(A_TH, seg_of(d3), 8);
    hold(A_HU, seg_of(d2), 8);
    hold(A_TE, seg_of(d1), 8);
    ones_cyc = cyc;
    hold(A_ON, seg_of(d0), 8);
    hold(A_BL, 7'b1111111, 8);
  endtask

  typedef struct {
    int          d3, d2, d1, d0;
    int          exp_num;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int oc, nv0, fe0;
    vecs[0] = '{1, 2, 3, 4, 1234, 16'h1234};
    vecs[1] = '{9, 9, 9, 9, 9999, 16'h9999};
    vecs[2] = '{5, 0, 0, 0, 5000, 16'h5000};
    vecs[3] = '{8, 0, 7, 0, 8070, 16'h8070};
    vecs[4] = '{0, 0, 0, 1, 1,    16'h0001};
    vecs[5] = '{0, 3, 0, 5, 305,  16'h0305};

    rst_n = 1'b0;
    wait_cyc(3);
    check("reset num_out", int'(num_out), 0);
    check("reset digits_out", int'(digits_out), 0);
    check("reset num_valid", int'(num_valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    wait_cyc(2);

    for (int i = 0; i < 6; i++) begin
      nv0 = nv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0, oc);
      check($sformatf("vec%0d pulses", i), nv_cnt - nv0, 1);
      check($sformatf("vec%0d num_out", i), int'(num_out), vecs[i].exp_num);
      check($sformatf("vec%0d digits_out", i), int'(digits_out), int'(vecs[i].exp_bcd));
      check($sformatf("vec%0d frame_err", i), fe_cnt - fe0, 0);
      check($sformatf("vec%0d latency", i), last_nv_cyc, oc + 9);
    end

    // hundreds bouncing between 5 and 6 never settles, then settles on 5
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    hold(A_TH, seg_of(1), 8);
    for (int k = 0; k < 6; k++)
      hold(A_HU, seg_of((k % 2 == 0) ? 5 : 6), 2);
    hold(A_HU, seg_of(5), 8);
    hold(A_TE, seg_of(2), 8);
    hold(A_ON, seg_of(0), 8);
    hold(A_BL, 7'b1111111, 8);
    check("bounce pulses", nv_cnt - nv0, 1);
    check("bounce num_out", int'(num_out), 1520);
    check("bounce frame_err", fe_cnt - fe0, 0);

    // hundreds skipped
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    hold(A_TH, seg_of(7), 8);
    hold(A_TE, seg_of(3), 8);
    check("skip frame_err", fe_cnt - fe0, 1);
    check("skip num_out", int'(num_out), 1520);
    hold(A_HU, seg_of(1), 8);
    hold(A_TE, seg_of(1), 8);
    hold(A_ON, seg_of(1), 8);
    hold(A_BL, 7'b1111111, 8);
    check("skip idle no pulse", nv_cnt - nv0, 0);
    check("skip idle no err", fe_cnt - fe0, 1);

    // blank hundreds code, then a clean frame
    fe0 = fe_cnt;
    hold(A_TH, seg_of(1), 8);
    hold(A_HU, 7'b1111111, 8);
    hold(A_BL, 7'b1111111, 8);
    check("blank frame_err", fe_cnt - fe0, 1);
    nv0 = nv_cnt;
    send_frame(0, 0, 4, 2, oc);
    check("after blank pulses", nv_cnt - nv0, 1);
    check("after blank num_out", int'(num_out), 42);
    check("after blank digits", int'(digits_out), 16'h0042);

    // reset during CONVERT
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    hold(A_TH, seg_of(5), 8);
    hold(A_HU, seg_of(6), 8);
    hold(A_TE, seg_of(7), 8);
    hold(A_ON, seg_of(8), 6);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    hold(A_ON, seg_of(8), 1);
    hold(A_BL, 7'b1111111, 12);
    check("convert reset pulses", nv_cnt - nv0, 0);
    check("convert reset err", fe_cnt - fe0, 0);
    check("convert reset num_out", int'(num_out), 0);
    check("convert reset digits", int'(digits_out), 0);

    // two identical frames
    nv0 = nv_cnt;
    send_frame(1, 2, 3, 4, oc);
    send_frame(1, 2, 3, 4, oc);
`ifdef SEVSEG_CHANGE_ONLY_EN
    check("repeat frame pulses", nv_cnt - nv0, 1);
`else
    check("repeat frame pulses", nv_cnt - nv0, 2);
`endif
    check("repeat frame num_out", int'(num_out), 1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
